// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch port, the data port and the unified
// single-port memory.
//   master : the arbiter (drives grants, responses, stalls, memory command)
//   slave  : requesters and memory (drive requests, payloads, memory response)
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [DATA_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_stall;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [3:0]            d_be;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_stall;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_stall,
        output d_gnt, d_rvalid, d_rdata, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_stall,
        input  d_gnt, d_rvalid, d_rdata, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory,
// one transaction outstanding at a time. The data port has priority unless
// fetch has been denied STARVE_LIMIT times in a row.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mem_port_arbiter_if.master (request, response, stall, memory)
//
// state | meaning
// IDLE  | accept one grant (combinational), register command and owner
// ISSUE | drive mem_req for one cycle; writes return to IDLE
// WAIT  | wait for mem_rvalid, capture mem_rdata for the owner
// RESP  | owner's rvalid high for one cycle
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.master   bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         starve_q, starve_d;
    logic                  owner_q, owner_d;      // 1 = data port
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic if_gnt, d_gnt, starve_full;
    logic in_issue, in_resp, busy;

    assign starve_full = (starve_q == CW'(STARVE_LIMIT));

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        be_d       = be_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.if_req && (!bus.d_req || starve_full)) begin
                    if_gnt = 1'b1;
                end else if (bus.d_req) begin
                    d_gnt = 1'b1;
                end

                if (if_gnt) begin
                    state_d  = ISSUE;
                    owner_d  = 1'b0;
                    addr_d   = bus.if_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    be_d     = 4'hF;
                    starve_d = '0;
                end else if (d_gnt) begin
                    state_d = ISSUE;
                    owner_d = 1'b1;
                    addr_d  = bus.d_addr;
                    we_d    = bus.d_we;
                    wdata_d = bus.d_wdata;
                    be_d    = bus.d_be;
                    if (bus.if_req && !starve_full) begin
                        starve_d = starve_q + CW'(1);
                    end
                end

                // A fetch that is not asking is not being starved.
                if (!bus.if_req) begin
                    starve_d = '0;
                end
            end
            ISSUE: begin
                state_d = we_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d = RESP;
                    if (owner_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            be_q       <= 4'h0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            be_q       <= be_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign in_issue = (state_q == ISSUE);
    assign in_resp  = (state_q == RESP);
    assign busy     = (state_q != IDLE);

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;

    // Command fields are gated so the memory bus is quiet between issues.
    assign bus.mem_req   = in_issue;
    assign bus.mem_we    = in_issue & we_q;
    assign bus.mem_addr  = in_issue ? addr_q  : '0;
    assign bus.mem_wdata = in_issue ? wdata_q : '0;
    assign bus.mem_be    = in_issue ? be_q    : 4'h0;

    assign bus.if_rvalid = in_resp & ~owner_q;
    assign bus.d_rvalid  = in_resp &  owner_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    // Stall while waiting for a grant, or while own transaction is in flight
    // up to (not including) the response cycle.
    assign bus.if_stall = (bus.if_req & ~if_gnt) | (busy & ~owner_q & ~in_resp);
    assign bus.d_stall  = (bus.d_req  & ~d_gnt)  | (busy &  owner_q & ~in_resp);
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_port_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst            = 1'b0;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.d_be       = 4'h0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;

        // Reset state
        #12;
        chk("rst_state",    32'(dut.state_q), 32'd0);
        chk("rst_starve",   32'(dut.starve_q), 32'd0);
        chk("rst_if_gnt",   32'(bus.if_gnt), 32'd0);
        chk("rst_d_gnt",    32'(bus.d_gnt), 32'd0);
        chk("rst_mem_req",  32'(bus.mem_req), 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata",  bus.d_rdata, 32'h0);
        chk("rst_stall",    32'({bus.if_stall, bus.d_stall}), 32'd0);

        // Fetch only; first grant in the first cycle after release
        step();
        rst = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        settle();
        chk("f_if_gnt",  32'(bus.if_gnt), 32'd1);
        chk("f_d_gnt",   32'(bus.d_gnt), 32'd0);
        chk("f_if_stall", 32'(bus.if_stall), 32'd0);
        step();
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h999;
        settle();
        chk("f_mem_req",  32'(bus.mem_req), 32'd1);
        chk("f_mem_addr", bus.mem_addr, 32'h100);
        chk("f_mem_we",   32'(bus.mem_we), 32'd0);
        chk("f_mem_be",   32'(bus.mem_be), 32'hF);
        chk("f_stall_iss", 32'(bus.if_stall), 32'd1);
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h00500093;
        settle();
        chk("f_wait_state", 32'(dut.state_q), 32'd2);
        chk("f_mem_req_lo", 32'(bus.mem_req), 32'd0);
        chk("f_mem_be_lo",  32'(bus.mem_be), 32'd0);
        chk("f_rvalid_early", 32'(bus.if_rvalid), 32'd0);
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        settle();
        chk("f_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("f_if_rdata",  bus.if_rdata, 32'h00500093);
        chk("f_d_rvalid",  32'(bus.d_rvalid), 32'd0);
        chk("f_stall_resp", 32'(bus.if_stall), 32'd0);
        step();
        chk("f_rvalid_one", 32'(bus.if_rvalid), 32'd0);
        chk("f_rdata_hold", bus.if_rdata, 32'h00500093);
        chk("f_idle",       32'(dut.state_q), 32'd0);

        // Simultaneous requests: data wins, fetch follows
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h200;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h2000;
        bus.d_wdata = 32'hDEADBEEF;
        bus.d_be    = 4'hF;
        settle();
        chk("s_d_gnt",   32'(bus.d_gnt), 32'd1);
        chk("s_if_gnt",  32'(bus.if_gnt), 32'd0);
        chk("s_if_stall", 32'(bus.if_stall), 32'd1);
        chk("s_d_stall", 32'(bus.d_stall), 32'd0);
        step();
        bus.d_req   = 1'b0;
        bus.d_wdata = 32'h11111111;
        settle();
        chk("s_mem_req",   32'(bus.mem_req), 32'd1);
        chk("s_mem_we",    32'(bus.mem_we), 32'd1);
        chk("s_mem_addr",  bus.mem_addr, 32'h2000);
        chk("s_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk("s_mem_be",    32'(bus.mem_be), 32'hF);
        chk("s_if_stall_iss", 32'(bus.if_stall), 32'd1);
        step();
        chk("s_starve1",  32'(dut.starve_q), 32'd1);
        chk("s_if_gnt2",  32'(bus.if_gnt), 32'd1);
        chk("s_if_stall_gnt", 32'(bus.if_stall), 32'd0);
        step();
        bus.if_req = 1'b0;
        settle();
        chk("s_starve0",    32'(dut.starve_q), 32'd0);
        chk("s_f_mem_addr", bus.mem_addr, 32'h200);
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE0001;
        step();
        bus.mem_rvalid = 1'b0;
        settle();
        chk("s_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("s_if_rdata",  bus.if_rdata, 32'hCAFE0001);
        step();

        // Starvation: back-to-back data writes with fetch pending
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h300;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_wdata = 32'h1;
        bus.d_be    = 4'h3;
        for (int k = 0; k < 4; k++) begin
            bus.d_addr = 32'h3000 + 32'(k * 4);
            settle();
            chk("v_starve_cnt", 32'(dut.starve_q), 32'(k));
            chk("v_d_gnt",  32'(bus.d_gnt), 32'd1);
            chk("v_if_gnt", 32'(bus.if_gnt), 32'd0);
            step();
            chk("v_mem_we",   32'(bus.mem_we), 32'd1);
            chk("v_mem_be",   32'(bus.mem_be), 32'h3);
            chk("v_mem_addr", bus.mem_addr, 32'h3000 + 32'(k * 4));
            step();
        end
        chk("v_starve_full", 32'(dut.starve_q), 32'd4);
        chk("v_if_forced",   32'(bus.if_gnt), 32'd1);
        chk("v_d_denied",    32'(bus.d_gnt), 32'd0);
        chk("v_d_stall",     32'(bus.d_stall), 32'd1);
        step();
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        settle();
        chk("v_starve_clr",  32'(dut.starve_q), 32'd0);
        chk("v_f_mem_addr",  bus.mem_addr, 32'h300);
        chk("v_f_mem_we",    32'(bus.mem_we), 32'd0);
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h77;
        step();
        bus.mem_rvalid = 1'b0;
        settle();
        chk("v_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("v_if_rdata",  bus.if_rdata, 32'h77);
        step();

        // Slow memory: data read answered after several WAIT cycles
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h4000;
        bus.d_be   = 4'hC;
        settle();
        chk("m_d_gnt", 32'(bus.d_gnt), 32'd1);
        step();
        bus.d_req  = 1'b0;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h600;
        settle();
        chk("m_mem_req",  32'(bus.mem_req), 32'd1);
        chk("m_mem_we",   32'(bus.mem_we), 32'd0);
        chk("m_mem_be",   32'(bus.mem_be), 32'hC);
        chk("m_mem_addr", bus.mem_addr, 32'h4000);
        chk("m_if_gnt_iss", 32'(bus.if_gnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("m_wait_state", 32'(dut.state_q), 32'd2);
            chk("m_d_stall",    32'(bus.d_stall), 32'd1);
            chk("m_no_if_gnt",  32'(bus.if_gnt), 32'd0);
            chk("m_no_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        end
        step();
        bus.if_req     = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hA5A5A5A5;
        settle();
        chk("m_still_wait", 32'(dut.state_q), 32'd2);
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        settle();
        chk("m_d_rvalid",   32'(bus.d_rvalid), 32'd1);
        chk("m_d_rdata",    bus.d_rdata, 32'hA5A5A5A5);
        chk("m_if_rvalid",  32'(bus.if_rvalid), 32'd0);
        chk("m_d_stall_resp", 32'(bus.d_stall), 32'd0);
        chk("m_if_rdata_hold", bus.if_rdata, 32'h77);
        step();
        chk("m_d_rvalid_one", 32'(bus.d_rvalid), 32'd0);
        chk("m_d_rdata_hold", bus.d_rdata, 32'hA5A5A5A5);
        chk("m_idle",         32'(dut.state_q), 32'd0);

        // Reset in the middle of a fetch read
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h500;
        settle();
        chk("r_if_gnt", 32'(bus.if_gnt), 32'd1);
        step();
        bus.if_req = 1'b0;
        step();
        chk("r_in_wait", 32'(dut.state_q), 32'd2);
        rst = 1'b0;
        settle();
        chk("r_state_idle", 32'(dut.state_q), 32'd0);
        chk("r_mem_req",    32'(bus.mem_req), 32'd0);
        chk("r_if_rdata",   bus.if_rdata, 32'h0);
        chk("r_d_rdata",    bus.d_rdata, 32'h0);
        chk("r_stalls",     32'({bus.if_stall, bus.d_stall}), 32'd0);
        step();
        rst            = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h00000BAD;
        settle();
        chk("r_late_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        settle();
        chk("r_no_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
        chk("r_idle",      32'(dut.state_q), 32'd0);
        chk("r_no_capture", bus.if_rdata, 32'h0);

        // Spurious response in IDLE
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234;
        step();
        bus.mem_rvalid = 1'b0;
        settle();
        chk("p_state",   32'(dut.state_q), 32'd0);
        chk("p_rvalid",  32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
        chk("p_if_rdata", bus.if_rdata, 32'h0);
        chk("p_d_rdata",  bus.d_rdata, 32'h0);
        step();
        chk("p_rvalid2", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data and address width.
REQ-002 Parameter STARVE_LIMIT, default 4, SHALL set the number of consecutive fetch denials that forces a fetch grant.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 if_req  in  1  fetch read request; if_addr  in  DATA_WIDTH  fetch address.
REQ-006 if_gnt  out  1  fetch accepted; if_rvalid  out  1  fetch data valid; if_rdata  out  DATA_WIDTH  fetch data.
REQ-007 d_req  in  1  data request; d_we  in  1  1=write; d_addr  in  DATA_WIDTH; d_wdata  in  DATA_WIDTH; d_be  in  4  byte enables.
REQ-008 d_gnt  out  1  data accepted; d_rvalid  out  1  load data valid; d_rdata  out  DATA_WIDTH  load data.
REQ-009 if_stall / d_stall  out  1  SHALL hold the fetch / memory pipeline stage.
REQ-010 mem_req  out  1; mem_we  out  1; mem_addr  out  DATA_WIDTH; mem_wdata  out  DATA_WIDTH; mem_be  out  4  unified single-port memory command.
REQ-011 mem_rvalid  in  1; mem_rdata  in  DATA_WIDTH  memory read response, latency of 1 or more cycles after mem_req.

Function
REQ-012 FSM SHALL have states IDLE, ISSUE, WAIT, RESP; one transaction outstanding at a time.
REQ-013 Grants SHALL occur only in IDLE; if_gnt and d_gnt are combinational, mutually exclusive, and never both high.
REQ-014 Arbitration in IDLE: d_req wins over if_req unless starve_cnt == STARVE_LIMIT, in which case if_req wins.
REQ-015 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each IDLE cycle with if_req=1 and d_gnt=1; it clears on if_gnt or when if_req=0 in IDLE.
REQ-016 On grant, the command (winner's addr; d_we/d_wdata/d_be for data; we=0, be=4'hF for fetch) and owner id SHALL be registered, and the FSM moves to ISSUE.
REQ-017 In ISSUE, mem_req=1 for exactly one cycle with the registered command; a write then returns to IDLE and a read goes to WAIT.
REQ-018 mem_rvalid SHALL be ignored in IDLE, ISSUE and RESP.
REQ-019 In WAIT, mem_rvalid=1 SHALL capture mem_rdata and move to RESP; with no mem_rvalid the FSM stays in WAIT indefinitely.
REQ-020 In RESP, the owner's rvalid SHALL be high for exactly one cycle with the captured data, then the FSM returns to IDLE; the non-owner's rvalid stays 0.
REQ-021 if_rdata and d_rdata SHALL hold their last captured value when rvalid is low.
REQ-022 if_stall = if_req & ~if_gnt, or a fetch is outstanding and not in its RESP cycle; d_stall is defined the same way for the data port.
REQ-023 Requesters hold req and payload stable until granted; payload changes after a grant SHALL NOT affect the issued command.
REQ-024 mem_we, mem_be and mem_wdata SHALL be 0 whenever mem_req=0.
REQ-025 Best case: a read takes 4 cycles from grant to rvalid with 1-cycle memory latency (grant, ISSUE, WAIT, RESP); a write takes 2 cycles to the next possible grant.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, starve_cnt=0, owner=fetch, and all outputs and captured registers to 0.
REQ-027 Reset during ISSUE/WAIT/RESP SHALL abandon the transaction with no rvalid after release; a late mem_rvalid is ignored in IDLE.
REQ-028 The first grant SHALL be possible in the first clk edge's cycle after rst deasserts.

Verification
REQ-029 Fetch only: if_req=1, if_addr=0x100, memory returns 0x00500093 one cycle after mem_req -> if_gnt in cycle 0, mem_req/mem_addr=0x100 in cycle 1, if_rvalid with if_rdata=0x00500093 in cycle 3.
REQ-030 Simultaneous requests: if_req=1 and d_req=1 with d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=0xF -> d_gnt first, mem_we=1 write issued, if_gnt at the next IDLE, if_stall high until then.
REQ-031 Starvation: d_req held high with back-to-back writes and if_req=1 -> after 4 data grants if_gnt is forced, starve_cnt returns to 0.
REQ-032 Slow memory: data read with mem_rvalid delayed 5 cycles -> FSM stays in WAIT, d_stall=1 throughout, d_rvalid exactly one cycle with correct data, no grants meanwhile.
REQ-033 Reset mid-read: rst=0 in WAIT, then mem_rvalid pulses after release -> no if_rvalid/d_rvalid, all outputs 0, FSM in IDLE.
REQ-034 Spurious response: mem_rvalid=1 in IDLE with no request -> no rvalid on either port, state unchanged.
